// File: rtl/param_alu_seq_pkg.sv
// Shared types for the handshaked parametrised ALU.
// Opcode map, FSM states and the multicycle-op predicate.
package param_alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP      = 4'h0,
    OP_ABSDIFF  = 4'h1,
    OP_LSR1     = 4'h2,
    OP_ONELSL   = 4'h3,
    OP_ONELSLM1 = 4'h4,
    OP_ADDU     = 4'h5,
    OP_INCIFSET = 4'h6,
    OP_SETNEG   = 4'h7,
    OP_LSL1     = 4'h8,
    OP_MIN      = 4'h9,
    OP_DECSETZ  = 4'hA,
    OP_DECSET1  = 4'hB,
    OP_ADDU2    = 4'hC,
    OP_STRMATCH = 4'hD
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MATCH,
    HOLD
  } state_e;

  function automatic logic is_multicycle(op_e op);
    return op == OP_STRMATCH;
  endfunction

endpackage

// File: rtl/param_alu_seq_if.sv
// Decode-side and writeback-side handshake bundle of the ALU.
// master drives operations and out_ready; slave is the ALU.
interface param_alu_seq_if #(
  parameter int WIDTH = 8
);
  import param_alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_e              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_o;
  logic             illegal_o;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  flag_o, illegal_o
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result,
    output flag_o, illegal_o
  );

endinterface

// File: rtl/param_alu_seq_palu_comb.sv
// Next result/flag for every single-cycle op of the ALU.
// PALU_ILLEGAL_TRAP_EN: opcodes 4'hE/4'hF yield 0 and raise ill_o.
module palu_comb
  import param_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flag_i,
  output logic [WIDTH-1:0] res_o,
  output logic             flag_o,
  output logic             ill_o
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   sum_a2;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] one_sh;
  logic             big_b;

  assign sum_ab = {1'b0, a_i} + {1'b0, b_i};
  assign sum_a2 = {1'b0, a_i} + (WIDTH+1)'(2);
  assign dec    = a_i - WIDTH'(1);
  assign big_b  = b_i >= WIDTH'(WIDTH);
  assign one_sh = big_b ? '0 : (WIDTH'(1) << b_i);

  always_comb begin
    res_o  = a_i;
    flag_o = flag_i;
    ill_o  = 1'b0;
    unique case (op_i)
      OP_NOP: ;
      OP_ABSDIFF:
        res_o = (a_i > b_i) ? a_i - b_i
                            : b_i - a_i;
      OP_LSR1: begin
        res_o  = a_i >> 1;
        flag_o = a_i[0];
      end
      OP_ONELSL:
        res_o = one_sh;
      OP_ONELSLM1:
        res_o = big_b ? ONES
                      : one_sh - WIDTH'(1);
      OP_ADDU: begin
        res_o  = sum_ab[WIDTH-1:0];
        flag_o = sum_ab[WIDTH];
      end
      OP_INCIFSET:
        res_o = a_i + WIDTH'(flag_i);
      OP_SETNEG:
        flag_o = a_i[WIDTH-1];
      OP_LSL1: begin
        res_o  = a_i << 1;
        flag_o = a_i[WIDTH-1];
      end
      OP_MIN:
        res_o = (a_i < b_i) ? a_i : b_i;
      OP_DECSETZ: begin
        res_o  = dec;
        flag_o = dec == '0;
      end
      OP_DECSET1: begin
        res_o  = dec;
        flag_o = dec == WIDTH'(1);
      end
      OP_ADDU2: begin
        res_o  = sum_a2[WIDTH-1:0];
        flag_o = sum_a2[WIDTH];
      end
      // strMatch is sequenced by the top
      OP_STRMATCH: ;
      default: begin
`ifdef PALU_ILLEGAL_TRAP_EN
        res_o = '0;
        ill_o = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/param_alu_seq.sv
// Handshaked ALU: FSM, strMatch window scanner, result and sticky flag.
// PALU_ILLEGAL_TRAP_EN enables the illegal-opcode trap in palu_comb.
module param_alu_seq
  import param_alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PAT_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  param_alu_seq_if.slave   bus
);

  localparam int NWIN = WIDTH - PAT_W + 1;
  localparam int IW   = $clog2(NWIN + 1);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST = IW'(NWIN - 1);

  state_e           st_q, st_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] win_q, win_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] c_res;
  logic             c_flag;
  logic             c_ill;
  logic             rdy;
  logic             acc;
  logic             hit;
  logic [CW-1:0]    cnt_nx;

  palu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op_i   (bus.op),
    .a_i    (bus.a),
    .b_i    (bus.b),
    .flag_i (flag_q),
    .res_o  (c_res),
    .flag_o (c_flag),
    .ill_o  (c_ill)
  );

  assign rdy = rst_n & ((st_q == IDLE) |
               ((st_q == HOLD) & bus.out_ready));
  assign acc = bus.in_valid & rdy;

  // window shifts right so its low bits are the current window
  assign hit    = win_q[PAT_W-1:0] == pat_q;
  assign cnt_nx = cnt_q + CW'(hit);

  always_comb begin
    st_d   = st_q;
    res_d  = res_q;
    flag_d = flag_q;
    ill_d  = ill_q;
    win_d  = win_q;
    pat_d  = pat_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      st_q == MATCH: begin
        win_d = win_q >> 1;
        idx_d = idx_q + IW'(1);
        cnt_d = cnt_nx;
        if (idx_q == LAST) begin
          st_d  = HOLD;
          res_d = WIDTH'(cnt_nx);
          ill_d = 1'b0;
        end
      end
      (st_q == HOLD) && !bus.out_ready: ;
      default: begin
        st_d = IDLE;
        if (acc) begin
          if (is_multicycle(bus.op)) begin
            st_d  = MATCH;
            win_d = bus.a;
            pat_d = bus.b[PAT_W-1:0];
            idx_d = '0;
            cnt_d = '0;
          end else begin
            st_d   = HOLD;
            res_d  = c_res;
            flag_d = c_flag;
            ill_d  = c_ill;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      res_q  <= '0;
      flag_q <= 1'b0;
      ill_q  <= 1'b0;
      win_q  <= '0;
      pat_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      res_q  <= res_d;
      flag_q <= flag_d;
      ill_q  <= ill_d;
      win_q  <= win_d;
      pat_q  <= pat_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = st_q == HOLD;
  assign bus.result    = res_q;
  assign bus.flag_o    = flag_q;
  assign bus.illegal_o = ill_q;

endmodule

// File: tb/tb_param_alu_seq.sv
// Bench for param_alu_seq at WIDTH=8, PAT_W=4: directed vectors,
// an op-level reference model and a scoreboard on every transfer.
module tb_param_alu_seq;
  import param_alu_seq_pkg::*;

  localparam int W = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_alu_seq_if #(.WIDTH(W)) bus();

  param_alu_seq #(
    .WIDTH (W),
    .PAT_W (P)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] res;
    logic       flg;
    logic       ill;
    string      nm;
  } exp_t;

  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
  } vec_t;

  exp_t q[$];
  exp_t ce;
  logic mflag;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference: op semantics in plain integer arithmetic
  function automatic void model(input op_e op, input int a,
                                input int b, input logic fin,
                                output logic [7:0] r,
                                output logic fo,
                                output logic il);
    int t;
    t  = a;
    fo = fin;
    il = 1'b0;
    case (op)
      OP_ABSDIFF:  t = (a > b) ? a - b : b - a;
      OP_LSR1:     begin t = a / 2; fo = (a % 2) == 1; end
      OP_ONELSL:   t = (b < W) ? 2 ** b : 0;
      OP_ONELSLM1: t = (b < W) ? 2 ** b - 1 : 255;
      OP_ADDU:     begin t = a + b; fo = t >= 256; end
      OP_INCIFSET: t = a + (fin ? 1 : 0);
      OP_SETNEG:   fo = a >= 128;
      OP_LSL1:     begin t = a * 2; fo = a >= 128; end
      OP_MIN:      t = (a < b) ? a : b;
      OP_DECSETZ:  begin t = (a + 255) % 256; fo = t == 0; end
      OP_DECSET1:  begin t = (a + 255) % 256; fo = t == 1; end
      OP_ADDU2:    begin t = a + 2; fo = t >= 256; end
      OP_STRMATCH: begin
        t = 0;
        for (int i = 0; i <= W - P; i++)
          if (((a >> i) % 16) == (b % 16)) t++;
      end
      OP_NOP: ;
      default: begin
`ifdef PALU_ILLEGAL_TRAP_EN
        t  = 0;
        il = 1'b1;
`endif
      end
    endcase
    r = 8'(t % 256);
  endfunction

  task automatic issue(input op_e op, input logic [7:0] a,
                       input logic [7:0] b);
    exp_t e;
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(op, int'(a), int'(b), mflag, e.res, e.flg, e.ill);
    mflag = e.flg;
    e.nm = op.name();
    q.push_back(e);
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  // scoreboard: every transferred result against the model
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_result", 1, 0);
      end else begin
        ce = q.pop_front();
        chk({"res_", ce.nm}, bus.result, ce.res);
        chk({"flag_", ce.nm}, bus.flag_o, ce.flg);
        chk({"ill_", ce.nm}, bus.illegal_o, ce.ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[$];
  int n;
  int rel;
  int c0;

  initial begin
    bus.in_valid = 1'b0;
    bus.op = OP_NOP;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    mflag = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flag", bus.flag_o, 0);
    chk("rst_illegal", bus.illegal_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", bus.in_ready, 1);

    issue(OP_ADDU, 8'hF0, 8'h20);
    chk("addu_valid", bus.out_valid, 1);
    chk("addu_res", bus.result, 8'h10);
    chk("addu_flag", bus.flag_o, 1);
    issue(OP_INCIFSET, 8'h05, 8'h00);
    chk("incifset_res", bus.result, 8'h06);

    issue(OP_STRMATCH, 8'b1011_0110, 8'h06);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      chk("match_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("match_latency", n, 5);
    chk("match_res", bus.result, 8'd2);

    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    issue(OP_ABSDIFF, 8'd3, 8'd9);
    chk("bp_res", bus.result, 8'd6);
    rel = 0;
    fork
      issue(OP_NOP, 8'h55, 8'h00);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("bp_hold_res", bus.result, 8'd6);
          chk("bp_hold_valid", bus.out_valid, 1);
          chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        rel = cyc;
      end
    join
    chk("bp_accept_cyc", acc_cyc, rel + 1);
    chk("bp_next_res", bus.result, 8'h55);

    issue(OP_MIN, 8'd7, 8'd2);
    c0 = acc_cyc;
    chk("b2b_min", bus.result, 8'd2);
    issue(OP_LSL1, 8'h81, 8'h00);
    chk("b2b_lsl1", bus.result, 8'h02);
    chk("b2b_lsl1_flag", bus.flag_o, 1);
    chk("b2b_cyc1", acc_cyc, c0 + 1);
    issue(OP_DECSETZ, 8'h01, 8'h00);
    chk("b2b_dsz", bus.result, 8'h00);
    chk("b2b_dsz_flag", bus.flag_o, 1);
    chk("b2b_cyc2", acc_cyc, c0 + 2);

    issue(OP_STRMATCH, 8'hFF, 8'h0F);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    mflag = 1'b0;
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_flag", bus.flag_o, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_stale", bus.out_valid, 0);
    issue(OP_ADDU, 8'd1, 8'd1);
    chk("post_abort_res", bus.result, 8'd2);
    chk("post_abort_flag", bus.flag_o, 0);

    issue(op_e'(4'hF), 8'h33, 8'h00);
`ifdef PALU_ILLEGAL_TRAP_EN
    chk("illegal_res", bus.result, 8'h00);
    chk("illegal_flag", bus.illegal_o, 1);
`else
    chk("illegal_res", bus.result, 8'h33);
    chk("illegal_flag", bus.illegal_o, 0);
`endif
    issue(OP_NOP, 8'h44, 8'h00);
    chk("illegal_clear", bus.illegal_o, 0);

    issue(OP_ONELSL, 8'h00, 8'd8);
    chk("onelsl_big", bus.result, 8'h00);
    issue(OP_ONELSLM1, 8'h00, 8'd8);
    chk("onelslm1_big", bus.result, 8'hFF);
    issue(OP_DECSETZ, 8'h00, 8'h00);
    chk("dsz_wrap", bus.result, 8'hFF);
    chk("dsz_wrap_flag", bus.flag_o, 0);

    tbl = '{
      '{OP_ONELSL, 8'h00, 8'd7},
      '{OP_ONELSL, 8'h00, 8'd200},
      '{OP_ONELSLM1, 8'h00, 8'd0},
      '{OP_ONELSLM1, 8'h00, 8'd3},
      '{OP_DECSET1, 8'h02, 8'h00},
      '{OP_DECSET1, 8'h00, 8'h00},
      '{OP_ADDU2, 8'hFE, 8'h00},
      '{OP_ADDU2, 8'hFF, 8'h00},
      '{OP_INCIFSET, 8'hFF, 8'h00},
      '{OP_LSR1, 8'h03, 8'h00},
      '{OP_SETNEG, 8'h80, 8'h00},
      '{OP_INCIFSET, 8'h10, 8'h00},
      '{OP_SETNEG, 8'h7F, 8'h00},
      '{OP_ABSDIFF, 8'd9, 8'd3},
      '{OP_ADDU, 8'hFF, 8'h01},
      '{OP_STRMATCH, 8'hAA, 8'h0A},
      '{OP_STRMATCH, 8'h00, 8'hF0},
      '{OP_MIN, 8'd200, 8'd100},
      '{op_e'(4'hE), 8'h12, 8'h34}
    };
    foreach (tbl[i]) issue(tbl[i].op, tbl[i].a, tbl[i].b);

    for (int i = 0; i < 24; i++) begin
      issue(op_e'(4'($urandom_range(15))),
            8'($urandom), 8'($urandom));
      if ((i % 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (12) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
